// File: rtl/cgra_pkg.sv
// Shared CGRA constants and types used by the TCDM port buffers.
package cgra_pkg;

  localparam int unsigned DATA_BUS_ADD_WIDTH  = 32;
  localparam int unsigned DATA_BUS_DATA_WIDTH = 32;

  localparam int unsigned TCDM_BUF_REQ_DEPTH = 4;
  localparam int unsigned TCDM_BUF_MAX_OUTST = 2;

  typedef struct packed {
    logic [DATA_BUS_ADD_WIDTH-1:0]  add;
    logic                           wen;
    logic [3:0]                     be;
    logic [DATA_BUS_DATA_WIDTH-1:0] wdata;
  } tcdm_req_entry_t;

endpackage

// File: rtl/cgra_sync_fifo.sv
// Generic synchronous FIFO, no fall-through; pointers carry an extra wrap bit
// so full and empty come straight from a pointer compare.
module cgra_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointers and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok_s) begin
      wr_ptr_d                  = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      mem_d[wr_ptr_q[AW-1:0]]   = wdata_i;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; empty pointers mask stale contents.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cgra_tcdm_port_buffer.sv
// Decouples one CGRA TCDM master port from the data-bus interconnect: queued
// in-order issue, capped outstanding count, 1-cycle registered response path.
module cgra_tcdm_port_buffer
  import cgra_pkg::*;
#(
  parameter int unsigned REQ_DEPTH = TCDM_BUF_REQ_DEPTH,
  parameter int unsigned MAX_OUTST = TCDM_BUF_MAX_OUTST,
  parameter int unsigned ADDR_W    = DATA_BUS_ADD_WIDTH,
  parameter int unsigned DATA_W    = DATA_BUS_DATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tcdm_req_i,
  input  logic [ADDR_W-1:0] tcdm_add_i,
  input  logic              tcdm_wen_i,
  input  logic [3:0]        tcdm_be_i,
  input  logic [DATA_W-1:0] tcdm_wdata_i,
  output logic              tcdm_gnt_o,
  output logic [DATA_W-1:0] tcdm_rdata_o,
  output logic              tcdm_rvalid_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_add_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_rvalid_i,
  output logic [3:0]        outst_o,
  output logic              err_o
);

  localparam int unsigned ENTRY_W     = ADDR_W + 1 + 4 + DATA_W;
  localparam logic [3:0]  MAX_OUTST_C = 4'(MAX_OUTST);

  logic [ENTRY_W-1:0] entry_in_s;
  logic [ENTRY_W-1:0] head_s;
  logic               full_s, empty_s;
  logic               push_s, pop_s, ret_s;

  logic [3:0]         outst_q, outst_d;
  logic               err_q, err_d;
  logic               rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  assign entry_in_s = {tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_wdata_i};

  cgra_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (entry_in_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Grant depends only on registered FIFO state, never on the incoming request.
  assign tcdm_gnt_o = ~full_s;
  assign push_s     = tcdm_req_i & tcdm_gnt_o;
  assign bus_req_o  = ~empty_s & (outst_q < MAX_OUTST_C);
  assign pop_s      = bus_req_o & bus_gnt_i;
  assign ret_s      = bus_rvalid_i & (outst_q != 4'd0);

  assign bus_add_o   = head_s[ENTRY_W-1 -: ADDR_W];
  assign bus_we_o    = head_s[DATA_W+4];
  assign bus_be_o    = head_s[DATA_W+3 -: 4];
  assign bus_wdata_o = head_s[DATA_W-1:0];

  assign outst_o       = outst_q;
  assign err_o         = err_q;
  assign tcdm_rvalid_o = rvalid_q;
  assign tcdm_rdata_o  = rdata_q;

  // Outstanding counter, sticky error and response stage next-state.
  always_comb begin
    outst_d  = outst_q;
    err_d    = err_q;
    rvalid_d = bus_rvalid_i;
    rdata_d  = rdata_q;
    case ({pop_s, ret_s})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
    if (bus_rvalid_i && (outst_q == 4'd0)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    if (bus_rvalid_i) begin
      rdata_d = bus_rdata_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q  <= 4'd0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      outst_q  <= outst_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cgra_tcdm_port_buffer.sv
// Bench for cgra_tcdm_port_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_cgra_tcdm_port_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          tcdm_req_i;
  logic [AW-1:0] tcdm_add_i;
  logic          tcdm_wen_i;
  logic [3:0]    tcdm_be_i;
  logic [DW-1:0] tcdm_wdata_i;
  logic          tcdm_gnt_o;
  logic [DW-1:0] tcdm_rdata_o;
  logic          tcdm_rvalid_o;
  logic          bus_req_o;
  logic [AW-1:0] bus_add_o;
  logic          bus_we_o;
  logic [3:0]    bus_be_o;
  logic [DW-1:0] bus_wdata_o;
  logic          bus_gnt_i;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_rvalid_i;
  logic [3:0]    outst_o;
  logic          err_o;

  always #5 clk = ~clk;

  cgra_tcdm_port_buffer #(
    .REQ_DEPTH (DEPTH),
    .MAX_OUTST (MAXO),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .tcdm_req_i    (tcdm_req_i),
    .tcdm_add_i    (tcdm_add_i),
    .tcdm_wen_i    (tcdm_wen_i),
    .tcdm_be_i     (tcdm_be_i),
    .tcdm_wdata_i  (tcdm_wdata_i),
    .tcdm_gnt_o    (tcdm_gnt_o),
    .tcdm_rdata_o  (tcdm_rdata_o),
    .tcdm_rvalid_o (tcdm_rvalid_o),
    .bus_req_o     (bus_req_o),
    .bus_add_o     (bus_add_o),
    .bus_we_o      (bus_we_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .outst_o       (outst_o),
    .err_o         (err_o)
  );

  typedef struct {
    logic [AW-1:0] add;
    logic          wen;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
  } ent_t;

  // Reference model: queued requests, in-flight count, sticky error, response.
  ent_t          mq[$];
  int            mo;
  bit            merr;
  bit            mrv;
  logic [DW-1:0] mrd;
  bit            mvalid;

  int n_vec;
  int n_fail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit req, input logic [AW-1:0] add, input bit wen,
                       input logic [3:0] be, input logic [DW-1:0] wd,
                       input bit bgnt, input bit brv, input logic [DW-1:0] brd);
    tcdm_req_i   = req;
    tcdm_add_i   = add;
    tcdm_wen_i   = wen;
    tcdm_be_i    = be;
    tcdm_wdata_i = wd;
    bus_gnt_i    = bgnt;
    bus_rvalid_i = brv;
    bus_rdata_i  = brd;
  endtask

  // One clock: compare outputs against the model, then advance the model.
  task automatic step();
    bit   gnt_e, breq_e, push, pop, ret;
    ent_t e;
    #1;
    gnt_e  = (mq.size() < DEPTH);
    breq_e = (mq.size() > 0) && (mo < MAXO);
    if (mvalid) begin
      chk("tcdm_gnt", tcdm_gnt_o, gnt_e);
      chk("bus_req", bus_req_o, breq_e);
      chk("outst", outst_o, mo);
      chk("err", err_o, merr);
      chk("tcdm_rvalid", tcdm_rvalid_o, mrv);
      chk("tcdm_rdata", tcdm_rdata_o, mrd);
      if (breq_e) begin
        chk("bus_add", bus_add_o, mq[0].add);
        chk("bus_we", bus_we_o, mq[0].wen);
        chk("bus_be", bus_be_o, mq[0].be);
        chk("bus_wdata", bus_wdata_o, mq[0].wdata);
      end
    end
    push    = tcdm_req_i && gnt_e;
    pop     = breq_e && bus_gnt_i;
    ret     = bus_rvalid_i && (mo != 0);
    e.add   = tcdm_add_i;
    e.wen   = tcdm_wen_i;
    e.be    = tcdm_be_i;
    e.wdata = tcdm_wdata_i;
    @(posedge clk);
    if (rst_i) begin
      mq.delete();
      mo     = 0;
      merr   = 0;
      mrv    = 0;
      mrd    = '0;
      mvalid = 1;
    end else begin
      if (bus_rvalid_i && mo == 0) merr = 1;
      mrv = bus_rvalid_i;
      if (bus_rvalid_i) mrd = bus_rdata_i;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      mo = mo + int'(pop) - int'(ret);
    end
    @(negedge clk);
  endtask

  // Let everything queued and in flight complete, bounded.
  task automatic drain();
    int cyc = 0;
    while ((mq.size() != 0 || mo != 0) && cyc < 40) begin
      drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, (mo > 0), 32'h0000_1111);
      step();
      cyc++;
    end
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0);
    chk("drain_bound", {63'd0, (mq.size() == 0 && mo == 0)}, 64'd1);
  endtask

  initial begin
    logic [AW-1:0] issued[$];
    int            idx;
    int            grants;
    int            cyc;
    bit            hold;
    ent_t          cur;

    n_vec  = 0;
    n_fail = 0;
    mvalid = 0;
    mo     = 0;
    merr   = 0;
    mrv    = 0;
    mrd    = '0;
    rst_i  = 1'b1;
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    step();
    rst_i = 1'b0;
    chk("rst_gnt", tcdm_gnt_o, 1);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_rvalid", tcdm_rvalid_o, 0);
    chk("rst_rdata", tcdm_rdata_o, 0);
    step();

    // Single write.
    drive(1'b1, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, 1'b0, '0);
    chk("wr_bus_req", bus_req_o, 1);
    chk("wr_bus_add", bus_add_o, 32'h100);
    chk("wr_bus_we", bus_we_o, 1);
    chk("wr_bus_wdata", bus_wdata_o, 32'hDEADBEEF);
    step();
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b1, 32'h0);
    step();
    chk("wr_rvalid", tcdm_rvalid_o, 1);
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0);
    step();
    chk("wr_rvalid_pulse", tcdm_rvalid_o, 0);

    // Single read.
    drive(1'b1, 32'h100, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b1, 32'hDEADBEEF);
    step();
    chk("rd_rvalid", tcdm_rvalid_o, 1);
    chk("rd_rdata", tcdm_rdata_o, 32'hDEADBEEF);
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0);
    step();
    chk("rd_rvalid_pulse", tcdm_rvalid_o, 0);
    chk("rd_rdata_hold", tcdm_rdata_o, 32'hDEADBEEF);

    // Backpressure: bus grant withheld, six back-to-back requests.
    idx    = 0;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'(idx * 4), 1'b1, 4'hF, 32'(idx), 1'b0, 1'b0, '0);
      if (tcdm_gnt_o) begin
        grants++;
        idx++;
      end
      step();
    end
    chk("bp_grants", grants, 4);
    chk("bp_gnt_low", tcdm_gnt_o, 0);
    chk("bp_head_add", bus_add_o, 32'h0);
    cyc = 0;
    while (issued.size() < 6 && cyc < 40) begin
      drive((idx < 6), 32'(idx * 4), 1'b1, 4'hF, 32'(idx), 1'b1, (mo > 0), '0);
      if (tcdm_req_i && tcdm_gnt_o) idx++;
      if (bus_req_o && bus_gnt_i) issued.push_back(bus_add_o);
      step();
      cyc++;
    end
    chk("bp_issued_count", issued.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < issued.size()) chk("bp_issue_order", issued[i], 64'(i * 4));
    end
    drain();

    // Outstanding cap.
    drive(1'b1, 32'h200, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    step();
    drive(1'b1, 32'h204, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    step();
    drive(1'b1, 32'h208, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    step();
    chk("cap_bus_req", bus_req_o, 0);
    chk("cap_outst2", outst_o, 2);
    drive(1'b1, 32'h20C, 1'b0, 4'hF, '0, 1'b1, 1'b1, 32'h1);
    step();
    chk("cap_outst1", outst_o, 1);
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, 1'b0, '0);
    step();
    chk("cap_outst_back2", outst_o, 2);
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, 1'b1, 32'h2);
    step();
    chk("cap_outst_ret", outst_o, 1);
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b1, 1'b1, 32'h3);
    step();
    chk("cap_pop_and_ret", outst_o, 1);
    drain();

    // Spurious response.
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b1, 32'h5A5A5A5A);
    step();
    chk("spur_err", err_o, 1);
    chk("spur_rvalid", tcdm_rvalid_o, 1);
    chk("spur_outst", outst_o, 0);
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0);
    step();
    chk("spur_err_sticky", err_o, 1);

    // Reset mid-operation: two outstanding, three queued.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(32'h300 + i * 4), 1'b1, 4'h3, 32'(i), 1'b1, 1'b0, '0);
      step();
    end
    chk("mid_outst_pre", outst_o, 2);
    drive(1'b0, '0, 1'b0, 4'h0, '0, 1'b0, 1'b0, '0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_rst_bus_req", bus_req_o, 0);
    chk("mid_rst_gnt", tcdm_gnt_o, 1);
    chk("mid_rst_outst", outst_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_rvalid", tcdm_rvalid_o, 0);
    step();

    // Random traffic; CGRA holds each request until granted.
    hold = 0;
    cur  = '{add: '0, wen: 1'b0, be: 4'h0, wdata: '0};
    for (int c = 0; c < 2000; c++) begin
      if (!hold) begin
        cur.add   = {$urandom_range(0, 1023), 2'b00};
        cur.wen   = 1'($urandom_range(0, 1));
        cur.be    = 4'($urandom_range(0, 15));
        cur.wdata = $urandom;
        hold      = ($urandom_range(0, 2) != 0);
      end
      drive(hold, cur.add, cur.wen, cur.be, cur.wdata,
            1'($urandom_range(0, 1)), (mo > 0) && ($urandom_range(0, 2) != 0), $urandom);
      rst_i = ($urandom_range(0, 299) == 0);
      if (tcdm_req_i && tcdm_gnt_o) hold = 0;
      step();
      rst_i = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
